arb_grant_tracker: RTL
======================

# arb_grant_tracker

Consumer side of the one-hot grant interface of the bus arbiter: takes the one-hot grant vector produced by the priority selector and turns it into a registered address-phase owner and a data-phase owner, each as one-hot plus binary index, for the fabric muxes. The block also supplies the feedback the selector consumes:
- `canchange`, a tenure-based rotation hint;
- per-requester starvation flags.

It sits between the priority selector and the master-side address/data muxes of the example SoC interconnect.

## Interface
- `W_REQ`, 8, number of requesters (2..32)
- `W_IDX`, `$clog2(W_REQ)`, index width
- `MAX_TENURE`, 16, consecutive accepted cycles before `canchange` asserts (1..255)
- `STARVE_LIMIT`, 64, wait cycles before a requester is flagged starved (1..255)

Ports (clock and reset first):
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  W_REQ  request vector from masters
- `gnt`  in  W_REQ  one-hot grant from priority selector (combinational)
- `lock`  in  1  current address-phase owner requests locked tenure
- `hready`  in  1  bus accepts current address phase / completes data phase
- `aphase_sel`  out  W_REQ  registered one-hot address-phase owner
- `aphase_idx`  out  W_IDX  binary index of `aphase_sel`
- `dphase_sel`  out  W_REQ  registered one-hot data-phase owner
- `dphase_idx`  out  W_IDX  binary index of `dphase_sel`
- `dphase_valid`  out  1  data phase in progress
- `canchange`  out  1  registered hint to selector: rotation permitted
- `starved`  out  W_REQ  per-requester starvation flag
- `gnt_err`  out  1  one-cycle pulse: illegal grant seen

## Operation
States: IDLE (`aphase_sel`=0), OWNED, LOCKED.

Legal grant (`gv`):
- `gnt & req` has exactly one bit set and `gnt & ~req` = 0.
- Otherwise treat the grant as 0. If `gnt` ≠ 0, pulse `gnt_err` the next cycle.
- `gnt_err` is evaluated every cycle, independent of `hready`.

On a cycle with `hready`=1:
- `dphase_sel` <= `aphase_sel`; `dphase_valid` <= |`aphase_sel`.
- IDLE/OWNED: `aphase_sel` <= `gv`. Next state is OWNED if `gv` ≠ 0, else IDLE.
- OWNED with `lock`=1 and `aphase_sel` ≠ 0: `aphase_sel` holds, go to LOCKED. `lock` is evaluated before `gnt`, so `gnt` is ignored.
- LOCKED with `lock`=1: `aphase_sel` holds.
- LOCKED with `lock`=0: rearbitrate as in OWNED in the same cycle.
- Owner's `req` drops while LOCKED: still held until `lock`=0.

On `hready`=0: `aphase_sel`, `dphase_sel`, `dphase_valid`, state and tenure all hold.

Indices:
- `*_idx` is the encoding of the matching one-hot vector; 0 when the vector is 0.
- Only legal grants reach the registers, so multi-hot encoding is undefined and unused.

Tenure counter (8-bit, saturating at 255):
- On `hready`=1 with the new `aphase_sel` equal to the old one and ≠ 0: increment.
- On `hready`=1 otherwise: clear.

`canchange`, registered:
- Next value = (tenure_next >= `MAX_TENURE`) && state_next ≠ LOCKED.

Starvation counters (per requester, 8-bit, saturating):
- Increment when `req[i]` && !`aphase_sel[i]`; clear otherwise.
- `starved[i]` = cnt[i] >= `STARVE_LIMIT`, registered with the counter.

## Timing
- All outputs are registered and take 0 at reset: state IDLE, all counters 0.
- Reset may assert at any cycle and aborts the in-flight data phase; `dphase_valid`=0 immediately on assertion (asynchronous).
- Grant to `aphase_sel`: 1 cycle (edge with `hready`=1).
- `aphase_sel` to `dphase_sel`: 1 further `hready`=1 edge.
- Back-to-back owners: address phase of B overlaps data phase of A; no bubble.
- `canchange` rises on the edge where tenure reaches `MAX_TENURE`, and falls on the edge entering LOCKED or on owner change.
- `gnt_err` is exactly one cycle per offending cycle.

## Structure
- Shared header `arb_defs.vh`: state encodings (IDLE=0, OWNED=1, LOCKED=2) and 8-bit counter width constant.
- Sub-module `onehot_to_index` (`W_REQ`, `W_IDX`): combinational OR-reduction encoder, instantiated twice.
- Starvation counters are a generate loop in the top.

## Test plan
- Reset, then `req`=0x04, `gnt`=0x04, `hready`=1 -> `aphase_sel`=0x04/idx 2 next cycle; `dphase_sel`=0x04, `dphase_valid`=1 one cycle later.
- Owner 0x04, `lock`=1, `gnt` switches to 0x01 -> state LOCKED, `aphase_sel` stays 0x04. Drop `lock` -> `aphase_sel`=0x01 on the same edge.
- `hready`=0 for 5 cycles with changing `gnt` -> all registered outputs and tenure frozen; resume -> 1-cycle update.
- `gnt`=0x06 or `gnt`=0x08 with `req`=0x01 -> `gnt_err` pulses 1 cycle; `aphase_sel`=0 on next `hready` edge.
- Same owner held with `MAX_TENURE`=4 -> `canchange`=1 after 4th accepted cycle. Other requester held off for `STARVE_LIMIT` cycles -> its `starved` bit sets, and clears the cycle after it becomes owner.
- Assert `rst_n`=0 mid-data-phase -> all outputs 0 asynchronously; state IDLE after release.

Source files
------------

// File: rtl/arb_grant_tracker_pkg.sv
// Shared definitions for the arbiter grant tracker: FSM states, counter width,
// and small helpers used by the tracker datapath.
package arb_grant_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // True when exactly one bit of v is set (vectors up to 32 requesters).
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // Saturating increment for tenure and starvation counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/arb_grant_tracker_onehot_to_index.sv
// One-hot to binary index encoder: OR of the indices of all set bits, which is
// exact for one-hot inputs and 0 for an all-zero input.
module onehot_to_index #(
    parameter int unsigned W_REQ = 8,
    parameter int unsigned W_IDX = $clog2(W_REQ)
) (
    input  logic [W_REQ-1:0] i_onehot,
    output logic [W_IDX-1:0] o_idx
);

    // OR-reduce the index of every asserted input bit.
    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < W_REQ; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | W_IDX'(i);
            end
        end
    end

endmodule

// File: rtl/arb_grant_tracker.sv
// Grant tracker: registers the address-phase and data-phase owners from the
// selector's one-hot grant, and feeds back rotation hint and starvation flags.
module arb_grant_tracker
    import arb_grant_tracker_pkg::*;
#(
    parameter int unsigned W_REQ        = 8,
    parameter int unsigned W_IDX        = $clog2(W_REQ),
    parameter int unsigned MAX_TENURE   = 16,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_REQ-1:0] req,
    input  logic [W_REQ-1:0] gnt,
    input  logic             lock,
    input  logic             hready,
    output logic [W_REQ-1:0] aphase_sel,
    output logic [W_IDX-1:0] aphase_idx,
    output logic [W_REQ-1:0] dphase_sel,
    output logic [W_IDX-1:0] dphase_idx,
    output logic             dphase_valid,
    output logic             canchange,
    output logic [W_REQ-1:0] starved,
    output logic             gnt_err
);

    localparam logic [CNT_W-1:0] L_MAX_TEN = CNT_W'(MAX_TENURE);
    localparam logic [CNT_W-1:0] L_STARVE  = CNT_W'(STARVE_LIMIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W_REQ-1:0]   r_aph;
    logic [W_REQ-1:0]   w_aph_nxt;
    logic [W_REQ-1:0]   r_dph;
    logic               r_dvalid;
    logic [CNT_W-1:0]   r_tenure;
    logic [CNT_W-1:0]   w_tenure_nxt;
    logic               r_cc;
    logic               w_cc_nxt;
    logic               r_err;
    logic [W_REQ-1:0]   w_hit;
    logic               w_legal;
    logic               w_err;
    logic [W_REQ-1:0]   w_gv;

    // Qualify the grant: exactly one granted requester, and nothing granted
    // to a non-requester; anything else is squashed and flagged.
    always_comb begin
        w_hit   = gnt & req;
        w_legal = is_onehot(32'(w_hit)) && ((gnt & ~req) == '0);
        w_gv    = w_legal ? gnt : '0;
        w_err   = (gnt != '0) && !w_legal;
    end

    // Next owner/state/tenure; lock is checked before the grant, so a locked
    // owner keeps the bus regardless of what the selector offers.
    always_comb begin
        w_state_nxt  = r_state;
        w_aph_nxt    = r_aph;
        w_tenure_nxt = r_tenure;
        if (hready) begin
            w_aph_nxt   = w_gv;
            w_state_nxt = (w_gv != '0) ? ST_OWNED : ST_IDLE;
            case (r_state)
                ST_OWNED, ST_LOCKED: begin
                    if (lock && (r_aph != '0)) begin
                        w_aph_nxt   = r_aph;
                        w_state_nxt = ST_LOCKED;
                    end
                end
                default: ;
            endcase
            w_tenure_nxt = ((w_aph_nxt == r_aph) && (r_aph != '0)) ? sat_inc(r_tenure) : '0;
        end
        w_cc_nxt = (w_tenure_nxt >= L_MAX_TEN) && (w_state_nxt != ST_LOCKED);
    end

    // Phase registers, tenure, rotation hint and grant-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_aph    <= '0;
            r_dph    <= '0;
            r_dvalid <= 1'b0;
            r_tenure <= '0;
            r_cc     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_aph    <= w_aph_nxt;
            r_tenure <= w_tenure_nxt;
            r_cc     <= w_cc_nxt;
            r_err    <= w_err;
            if (hready) begin
                r_dph    <= r_aph;
                r_dvalid <= (r_aph != '0);
            end
        end
    end

    for (genvar g = 0; g < W_REQ; g++) begin : g_starve
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_flag;

        assign w_cnt_nxt = (req[g] && !r_aph[g]) ? sat_inc(r_cnt) : '0;

        // Count cycles requester g waits without owning the address phase.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_flag <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_flag <= (w_cnt_nxt >= L_STARVE);
            end
        end

        assign starved[g] = r_flag;
    end

    onehot_to_index #(.W_REQ(W_REQ), .W_IDX(W_IDX)) u_aph_idx (
        .i_onehot (r_aph),
        .o_idx    (aphase_idx)
    );

    onehot_to_index #(.W_REQ(W_REQ), .W_IDX(W_IDX)) u_dph_idx (
        .i_onehot (r_dph),
        .o_idx    (dphase_idx)
    );

    assign aphase_sel   = r_aph;
    assign dphase_sel   = r_dph;
    assign dphase_valid = r_dvalid;
    assign canchange    = r_cc;
    assign gnt_err      = r_err;

endmodule
